// File: rtl/ps2_key_event_rx.sv
// PS/2 keyboard receiver: synchroniser, clock filter, 11-bit deframer, make/break/E0 decoder and FWFT event FIFO.
// Define PS2_EXTENDED_EN to decode the E0 prefix into ev_ext; otherwise E0 bytes are ignored and ev_ext is 0.
module ps2_key_event_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 25000
) (
  input  logic                          clk25,
  input  logic                          reset,
  input  logic                          ps2clk,
  input  logic                          ps2data,
  input  logic                          ev_ready,
  input  logic                          err_clr,
  output logic                          ev_valid,
  output logic [7:0]                    ev_code,
  output logic                          ev_break,
  output logic                          ev_ext,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          frame_err
);

  localparam int HALF = FILTER_LEN / 2;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam int IW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT_CYCLES);
`ifdef PS2_EXTENDED_EN
  localparam int EW = 10;
`else
  localparam int EW = 9;
`endif

  logic [1:0]            clk_sync_reg, data_sync_reg;
  logic [FILTER_LEN-1:0] filt_reg;
  logic                  clk_s, data_s, fall;

  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      clk_sync_reg  <= 2'b00;
      data_sync_reg <= 2'b00;
      filt_reg      <= '0;
    end else begin
      clk_sync_reg  <= {clk_sync_reg[0], ps2clk};
      data_sync_reg <= {data_sync_reg[0], ps2data};
      filt_reg      <= {filt_reg[FILTER_LEN-2:0], clk_s};
    end
  end

  assign clk_s  = clk_sync_reg[1];
  assign data_s = data_sync_reg[1];
  // Bit 0 is the newest sample: a clean fall is a settled-high half followed by a settled-low half.
  assign fall   = (&filt_reg[FILTER_LEN-1:HALF]) & ~(|filt_reg[HALF-1:0]);

  logic [3:0]    bit_cnt_reg;
  logic [9:0]    shift_reg;
  logic [IW-1:0] idle_reg;
  logic          byte_ok_reg, frame_err_reg, frame_good, timeout;
  logic [7:0]    byte_reg;

  // shift_reg[0]=start, [8:1]=data, [9]=parity; the stop bit is read live on the last edge.
  assign frame_good = ~shift_reg[0] & data_s & (^shift_reg[9:1]);
  assign timeout    = (bit_cnt_reg != 4'd0) && (idle_reg == IDLE_MAX);

  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      bit_cnt_reg   <= 4'd0;
      shift_reg     <= '0;
      idle_reg      <= '0;
      byte_ok_reg   <= 1'b0;
      byte_reg      <= 8'h00;
      frame_err_reg <= 1'b0;
    end else begin
      byte_ok_reg   <= 1'b0;
      frame_err_reg <= 1'b0;
      if (fall) begin
        idle_reg <= '0;
        if (bit_cnt_reg < 4'd10) begin
          shift_reg   <= {data_s, shift_reg[9:1]};
          bit_cnt_reg <= bit_cnt_reg + 4'd1;
        end else begin
          bit_cnt_reg <= 4'd0;
          if (frame_good) begin
            byte_ok_reg <= 1'b1;
            byte_reg    <= shift_reg[8:1];
          end else begin
            frame_err_reg <= 1'b1;
          end
        end
      end else if (timeout) begin
        idle_reg      <= '0;
        bit_cnt_reg   <= 4'd0;
        frame_err_reg <= 1'b1;
      end else if (idle_reg != IDLE_MAX) begin
        idle_reg <= idle_reg + IW'(1);
      end
    end
  end

  assign frame_err = frame_err_reg;

  logic          brk_reg, is_f0, is_e0, push_req;
  logic [EW-1:0] push_data;

  assign is_f0    = (byte_reg == 8'hF0);
  assign is_e0    = (byte_reg == 8'hE0);
  assign push_req = byte_ok_reg & ~is_f0 & ~is_e0;

`ifdef PS2_EXTENDED_EN
  logic ext_reg;
  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      brk_reg <= 1'b0;
      ext_reg <= 1'b0;
    end else if (frame_err_reg || push_req) begin
      brk_reg <= 1'b0;
      ext_reg <= 1'b0;
    end else if (byte_ok_reg) begin
      if (is_f0) brk_reg <= 1'b1;
      if (is_e0) ext_reg <= 1'b1;
    end
  end
  assign push_data = {ext_reg, brk_reg, byte_reg};
`else
  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      brk_reg <= 1'b0;
    end else if (frame_err_reg || push_req) begin
      brk_reg <= 1'b0;
    end else if (byte_ok_reg && is_f0) begin
      brk_reg <= 1'b1;
    end
  end
  assign push_data = {brk_reg, byte_reg};
`endif

  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg;
  logic          overflow_reg, full, do_push, do_pop;
  logic [EW-1:0] head;

  assign full    = (count_reg == CW'(FIFO_DEPTH));
  assign do_pop  = ev_valid & ev_ready;
  // A full FIFO still accepts a push when the head is popped in the same cycle.
  assign do_push = push_req & (~full | do_pop);

  always_ff @(posedge clk25) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      if (do_push && !do_pop)      count_reg <= count_reg + CW'(1);
      else if (do_pop && !do_push) count_reg <= count_reg - CW'(1);
      if (push_req && full && !do_pop) overflow_reg <= 1'b1;
      else if (err_clr)                overflow_reg <= 1'b0;
    end
  end

  assign head       = mem[rd_ptr_reg];
  assign ev_valid   = (count_reg != '0);
  assign fifo_count = count_reg;
  assign overflow   = overflow_reg;
  assign ev_code    = ev_valid ? head[7:0] : 8'h00;
  assign ev_break   = ev_valid & head[8];
`ifdef PS2_EXTENDED_EN
  assign ev_ext     = ev_valid & head[9];
`else
  assign ev_ext     = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_key_event_rx.sv
// Randomised bench for ps2_key_event_rx: PS/2 frame driver, queue-based event model and status checks.
module tb_ps2_key_event_rx;
  localparam int FL = 8;
  localparam int FD = 8;
  localparam int TO = 300;
  localparam int HP = 20;

  logic       clk25 = 1'b0, reset = 1'b1, ps2clk = 1'b1, ps2data = 1'b1;
  logic       ev_ready = 1'b0, err_clr = 1'b0;
  logic       ev_valid, ev_break, ev_ext, overflow, frame_err;
  logic [7:0] ev_code;
  logic [3:0] fifo_count;

  ps2_key_event_rx #(.FILTER_LEN(FL), .FIFO_DEPTH(FD), .TIMEOUT_CYCLES(TO)) dut (
    .clk25(clk25), .reset(reset), .ps2clk(ps2clk), .ps2data(ps2data),
    .ev_ready(ev_ready), .err_clr(err_clr), .ev_valid(ev_valid), .ev_code(ev_code),
    .ev_break(ev_break), .ev_ext(ev_ext), .fifo_count(fifo_count),
    .overflow(overflow), .frame_err(frame_err)
  );

  always #20 clk25 = ~clk25;

  int total = 0, bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: prefix flags, expected event queue, sticky overflow, error pulse count.
  bit         m_brk = 0, m_ext = 0, exp_ovf = 0;
  logic [9:0] exp_q[$];
  int         exp_fe = 0, fe_cycles = 0, fe_pulses = 0;
  logic       fe_prev = 1'b0;

  always @(negedge clk25) begin
    if (frame_err) fe_cycles++;
    if (frame_err && !fe_prev) fe_pulses++;
    fe_prev = frame_err;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk25);
    #1;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit badpar);
    if (badpar) begin
      exp_fe++;
      m_brk = 0;
      m_ext = 0;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else if (b == 8'hE0) begin
`ifdef PS2_EXTENDED_EN
      m_ext = 1;
`endif
    end else begin
      if (exp_q.size() < FD) exp_q.push_back({m_ext, m_brk, b});
      else exp_ovf = 1;
      m_brk = 0;
      m_ext = 0;
    end
  endtask

  // mode 1: check event latency on the stop edge; mode 2: check frame_err pulse timing.
  task automatic send_bits(input logic [7:0] b, input bit badpar, input int nbits, input int mode);
    logic [10:0] fr;
    logic        p;
    p  = ~(^b) ^ badpar;
    fr = {1'b1, p, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      cyc(1);
      ps2data = fr[i];
      cyc(HP);
      ps2clk = 1'b0;
      if (i == 10 && mode == 1) begin
        cyc(7); check_eq("lat_before", fifo_count, 0);
        cyc(1); check_eq("lat_after", fifo_count, 1);
        cyc(HP - 8);
      end else if (i == 10 && mode == 2) begin
        cyc(6); check_eq("ferr_before", frame_err, 0);
        cyc(1); check_eq("ferr_pulse", frame_err, 1);
        cyc(1); check_eq("ferr_after", frame_err, 0);
        cyc(HP - 8);
      end else begin
        cyc(HP);
      end
      ps2clk = 1'b1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input bit badpar, input int mode);
    send_bits(b, badpar, 11, mode);
    model_byte(b, badpar);
    cyc(10);
  endtask

  task automatic check_status(input string tag);
    check_eq({tag, "_count"}, fifo_count, exp_q.size());
    check_eq({tag, "_ovf"}, overflow, exp_ovf);
    check_eq({tag, "_fe_cycles"}, fe_cycles, exp_fe);
    check_eq({tag, "_fe_pulses"}, fe_pulses, exp_fe);
  endtask

  task automatic drain(input string tag);
    logic [9:0] e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_eq({tag, "_valid"}, ev_valid, 1);
      check_eq({tag, "_code"}, ev_code, e[7:0]);
      check_eq({tag, "_break"}, ev_break, e[8]);
      check_eq({tag, "_ext"}, ev_ext, e[9]);
      ev_ready = 1'b1;
      cyc(1);
      ev_ready = 1'b0;
    end
    check_eq({tag, "_empty_valid"}, ev_valid, 0);
    check_eq({tag, "_empty_code"}, {ev_code, ev_break, ev_ext}, 0);
    check_eq({tag, "_empty_count"}, fifo_count, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_outs"}, {ev_valid, ev_code, ev_break, ev_ext, fifo_count, overflow, frame_err}, 0);
  endtask

  initial begin
    logic [7:0] b;
    int         r;
    bit         bp;

    cyc(5);
    check_reset_outputs("reset");
    reset = 1'b0;
    cyc(20);

    send_frame(8'h1C, 0, 1);
    check_status("make");
    drain("make");

    send_frame(8'hF0, 0, 0);
    check_eq("f0_no_event", fifo_count, 0);
    send_frame(8'h1C, 0, 0);
    drain("break");

    send_frame(8'hE0, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_frame(8'h75, 0, 0);
    drain("ext_break");

    send_frame(8'hF0, 0, 0);
    send_frame(8'h1C, 1, 2);
    check_status("parity");
    send_frame(8'h1C, 0, 0);
    drain("after_err");

    for (int i = 0; i < 9; i++) send_frame(8'(8'h10 + i), 0, 0);
    check_status("overflow");
    drain("ovf_pop");
    cyc(1); err_clr = 1'b1;
    cyc(1); err_clr = 1'b0;
    exp_ovf = 0;
    check_status("err_clr");

    send_frame(8'hF0, 0, 0);
    send_bits(8'h5A, 0, 5, 0);
    cyc(TO + 50);
    exp_fe++;
    m_brk = 0;
    m_ext = 0;
    check_status("timeout");
    send_frame(8'h29, 0, 0);
    drain("after_timeout");

    for (int n = 0; n < 45; n++) begin
      r  = $urandom_range(0, 99);
      b  = (r < 20) ? 8'hF0 : (r < 32) ? 8'hE0 : 8'($urandom_range(0, 255));
      bp = ($urandom_range(0, 9) == 0);
      send_frame(b, bp, 0);
      check_status("rand");
      if (exp_q.size() >= 6 || $urandom_range(0, 3) == 0) drain("rand_pop");
    end
    drain("rand_final");

    send_frame(8'h33, 0, 0);
    send_frame(8'hF0, 0, 0);
    send_bits(8'h5A, 0, 4, 0);
    cyc(3);
    #7 reset = 1'b1;
    cyc(1);
    check_reset_outputs("midreset");
    exp_q.delete();
    m_brk = 0;
    m_ext = 0;
    exp_ovf = 0;
    reset = 1'b0;
    cyc(20);
    send_frame(8'h1C, 0, 0);
    check_status("post_reset");
    drain("post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ps2_key_event_rx.md
# ps2_key_event_rx

Parametrised PS/2 keyboard receiver for the clk25 domain. It synchronises and filters the PS/2 clock and deframes 11-bit packets. It decodes make, break (F0) and extended (E0) prefixes into key events and buffers them in a first-word-fall-through FIFO with a valid/ready handshake. It sits between the PS/2 pins and game/control logic, and replaces the single-scancode, release-only receiver.

## Interface
- FILTER_LEN, 8: ps2clk filter window in samples; even, ≥4.
- FIFO_DEPTH, 8: event FIFO entries; power of two, ≥2.
- TIMEOUT_CYCLES, 25000: clk25 cycles without a falling edge before a partial frame is aborted.
- clk25  in  1  system clock, 25 MHz.
- reset  in  1  reset, asynchronous, active-high; clock clk25.
- ps2clk  in  1  PS/2 clock pin, asynchronous.
- ps2data  in  1  PS/2 data pin, asynchronous.
- ev_ready  in  1  consumer accepts the head event.
- err_clr  in  1  clears `overflow` (one-cycle pulse).
- ev_valid  out  1  FIFO non-empty.
- ev_code  out  8  head event scancode.
- ev_break  out  1  head event is a key release.
- ev_ext  out  1  head event carried an E0 prefix.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupied entries.
- overflow  out  1  sticky: an event was dropped because the FIFO was full.
- frame_err  out  1  one-cycle pulse on a bad or aborted frame.

## Operation
- **Input stage.** ps2clk and ps2data each pass through a 2-flop synchroniser.
- **Filter.** A FILTER_LEN shift register holds synchronised ps2clk and resets to all zeros. A falling edge is detected when the oldest FILTER_LEN/2 samples are all 1 and the newest FILTER_LEN/2 are all 0.
- **Deframer.**
  - A bit counter runs 0..10.
  - On each edge with counter <10, synchronised ps2data shifts in LSB-first and the counter increments.
  - On the edge with counter ==10, the frame is checked: start==0, stop==1, and odd parity over 8 data bits plus the parity bit. The counter then returns to 0.
- **Timeout.** An idle counter resets on every edge. If the bit counter is ≠0 and the idle count reaches TIMEOUT_CYCLES, the bit counter returns to 0, frame_err pulses, and the prefix flags clear.
- **Decoder.** Two flags, brk and ext, are reset 0.
  - Valid byte F0: set brk.
  - Valid byte E0: set ext.
  - Any other valid byte: push {ext, brk, byte} to the FIFO, then clear both flags.
  - Invalid frame: frame_err pulse, both flags cleared, byte discarded.
- **FIFO.**
  - Push when full: the event is dropped and overflow is set.
  - overflow clears only on err_clr or reset. If err_clr and a new overflow occur in the same cycle, overflow stays 1.
  - Pop happens when ev_valid && ev_ready.
  - Push and pop in the same cycle succeed, including when full; fifo_count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - ev_code, ev_break and ev_ext read 0 whenever ev_valid==0.
- **Reset.**
  - All outputs 0.
  - Bit counter, idle counter, flags, FIFO pointers and filter cleared.
  - Reset mid-frame discards the partial frame; the next start bit begins a fresh frame.

## Timing
- Edge detect occurs FILTER_LEN/2+2 cycles after the ps2clk pin falls. ps2data is sampled from its synchroniser in the detect cycle.
- If the stop-bit edge is detected in cycle E:
  - frame_err is high in E+1 only.
  - The FIFO write happens at the E+1 clock edge.
  - ev_valid and fifo_count reflect the new event from E+2.
- A pop at clock edge P presents the next head, or ev_valid=0, from P+1.
- No combinational path from ev_ready to ev_valid.

## Configuration
- PS2_EXTENDED_EN defined: E0 decoding as above; ev_ext reports the prefix.
- PS2_EXTENDED_EN undefined:
  - A valid E0 byte is discarded without event and without touching brk.
  - The ext flag is not built and ev_ext is tied 0.

## Test plan
- Frame 0x1C with correct parity -> one event code=0x1C, break=0, ext=0; fifo_count=1 at E+2.
- Frames F0, 1C -> exactly one event code=0x1C, break=1; no event for F0.
- Frames E0, F0, 75:
  - With macro: one event code=0x75, break=1, ext=1.
  - Without macro: code=0x75, break=1, ext=0.
- Frame 0x1C with flipped parity bit after F0 -> frame_err one-cycle pulse; no event; a following 0x1C gives break=0.
- 9 events with ev_ready=0, FIFO_DEPTH=8 -> fifo_count=8, overflow=1, the first 8 codes pop in order. err_clr then clears overflow.
- 5 bits, then ps2clk idle for TIMEOUT_CYCLES -> frame_err pulse, bit counter 0; a following full 0x29 frame yields event code=0x29. Assert reset mid-frame -> all outputs 0 and the next frame decodes correctly.
